// File: rtl/bg_pkg.sv
// Shared definitions for the background-mean unit and the pe array:
// FSM state encoding, default frame geometry and accumulator width rule.
package bg_pkg;

    localparam int unsigned NUM_PE_DEF = 25;
    localparam int unsigned SUM_W_DEF  = 9;

    // One-hot so each state flag is a single register bit.
    typedef enum logic [3:0] {
        ST_INIT = 4'b0001,
        ST_ACC  = 4'b0010,
        ST_DIV  = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

    // Accumulator width that holds num_pe full-scale sums without overflow.
    function automatic int unsigned acc_width(input int unsigned sum_w,
                                              input int unsigned num_pe);
        return sum_w + $clog2(num_pe);
    endfunction

    localparam int unsigned ACC_W_DEF = acc_width(SUM_W_DEF, NUM_PE_DEF);

endpackage

// File: rtl/seq_divider.sv
// Restoring divider by a constant, one quotient bit per step, MSB first.
// Ports: clk/reset (sync, active-high), clr clears state, load captures the
// dividend, step performs one iteration, mean_c is the low OUT_W bits of the
// quotient as it will be after this cycle's step.
module seq_divider #(
    parameter int unsigned DVD_W   = 14,
    parameter int unsigned OUT_W   = 9,
    parameter int unsigned DIVISOR = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             step,
    input  logic [DVD_W-1:0] dividend,
    output logic [OUT_W-1:0] mean_c
);

    // Remainder is always below DIVISOR between steps.
    localparam int unsigned REM_W = $clog2(DIVISOR + 1);

    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_nxt;
    logic [REM_W:0]   shifted;
    logic [DVD_W-1:0] quo;
    logic [DVD_W-1:0] quo_nxt;

    // One restoring iteration: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_nxt = rem;
        quo_nxt = quo;
        shifted = {rem, quo[DVD_W-1]};
        if (step) begin
            if (shifted >= (REM_W+1)'(DIVISOR)) begin
                rem_nxt = REM_W'(shifted - (REM_W+1)'(DIVISOR));
                quo_nxt = {quo[DVD_W-2:0], 1'b1};
            end else begin
                rem_nxt = shifted[REM_W-1:0];
                quo_nxt = {quo[DVD_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            rem <= '0;
            quo <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
        end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
        end
    end

    assign mean_c = quo_nxt[OUT_W-1:0];

endmodule

// File: rtl/bg_mean_unit.sv
// Averages one frame of NUM_PE per-channel sums into red/green/blue means.
// Ports: Clk, Reset (sync, active-high), Start begins a frame, sum_valid with
// red/green/blue_sum supply samples, Ack releases a finished result.
// red/green/blue_exp hold the last completed means, Done flags a waiting
// result, Qi/Qacc/Qdiv/Qd are the one-hot state flags.
module bg_mean_unit
    import bg_pkg::*;
#(
    parameter int unsigned NUM_PE = NUM_PE_DEF,
    parameter int unsigned SUM_W  = SUM_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic             sum_valid,
    input  logic [SUM_W-1:0] red_sum,
    input  logic [SUM_W-1:0] green_sum,
    input  logic [SUM_W-1:0] blue_sum,
    output logic [SUM_W-1:0] red_exp,
    output logic [SUM_W-1:0] green_exp,
    output logic [SUM_W-1:0] blue_exp,
    output logic             Done,
    output logic             Qi,
    output logic             Qacc,
    output logic             Qdiv,
    output logic             Qd
);

    localparam int unsigned ACC_W  = acc_width(SUM_W, NUM_PE);
    localparam int unsigned CNT_W  = $clog2(NUM_PE + 1);
    localparam int unsigned DCNT_W = $clog2(ACC_W + 1);

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]            cnt;
    logic [DCNT_W-1:0]           div_cnt;
    logic [2:0][SUM_W-1:0]       sum_in;
    logic [2:0][ACC_W-1:0]       acc;
    logic [2:0][ACC_W-1:0]       acc_nxt;
    logic [2:0][SUM_W-1:0]       mean_c;
    logic [2:0][SUM_W-1:0]       exp_q;

    logic cnt_last;
    logic div_end;
    logic clr;
    logic acc_en;
    logic last_sample;
    logic div_step;
    logic div_last;

    assign sum_in   = {blue_sum, green_sum, red_sum};
    assign cnt_last = (cnt == CNT_W'(NUM_PE - 1));
    assign div_end  = (div_cnt == DCNT_W'(ACC_W - 1));

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (Start)                  state_nxt = ST_ACC;
            ST_ACC:  if (sum_valid && cnt_last)  state_nxt = ST_DIV;
            ST_DIV:  if (div_end)                state_nxt = ST_DONE;
            ST_DONE: if (Ack)                    state_nxt = ST_INIT;
            default:                             state_nxt = ST_INIT;
        endcase
    end

    // State flags and datapath controls
    always_comb begin
        Qi          = 1'b0;
        Qacc        = 1'b0;
        Qdiv        = 1'b0;
        Qd          = 1'b0;
        clr         = 1'b0;
        acc_en      = 1'b0;
        last_sample = 1'b0;
        div_step    = 1'b0;
        div_last    = 1'b0;
        case (state)
            ST_INIT: begin
                Qi  = 1'b1;
                clr = Start;
            end
            ST_ACC: begin
                Qacc        = 1'b1;
                acc_en      = sum_valid;
                last_sample = sum_valid && cnt_last;
            end
            ST_DIV: begin
                Qdiv     = 1'b1;
                div_step = 1'b1;
                div_last = div_end;
            end
            ST_DONE: begin
                Qd = 1'b1;
            end
            default: begin
                Qi = 1'b1;
            end
        endcase
    end

    assign Done = Qd;

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            acc_nxt[c] = acc[c] + ACC_W'(sum_in[c]);
        end
    end

    // Accumulators, sample/step counters and result registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc     <= '0;
            cnt     <= '0;
            div_cnt <= '0;
            exp_q   <= '0;
        end else begin
            if (clr) begin
                acc     <= '0;
                cnt     <= '0;
                div_cnt <= '0;
            end else if (acc_en) begin
                acc <= acc_nxt;
                cnt <= cnt + CNT_W'(1);
            end
            if (div_step) begin
                div_cnt <= div_cnt + DCNT_W'(1);
            end
            if (div_last) begin
                exp_q <= mean_c;
            end
        end
    end

    // Dividers load the final sums on the last sample, so DIV is pure stepping.
    for (genvar c = 0; c < 3; c++) begin : g_div
        seq_divider #(
            .DVD_W   (ACC_W),
            .OUT_W   (SUM_W),
            .DIVISOR (NUM_PE)
        ) u_div (
            .clk      (Clk),
            .reset    (Reset),
            .clr      (clr),
            .load     (last_sample),
            .step     (div_step),
            .dividend (acc_nxt[c]),
            .mean_c   (mean_c[c])
        );
    end

    assign red_exp   = exp_q[0];
    assign green_exp = exp_q[1];
    assign blue_exp  = exp_q[2];

endmodule
